// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, branch opcode,
// FSM encoding, FIFO entry layout and the predecode branch-target helper.
package pc_fetch_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [4:0]  OP_B             = 5'b00010;
  localparam int          FIFO_DEPTH       = 2;
  localparam logic [1:0]  FIFO_FULL        = 2'(FIFO_DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
    logic        pred;
  } fetch_entry_t;

  // Target of an unconditional B: the offset is relative to the following word.
  function automatic logic [15:0] branchTarget(input logic [15:0] pc,
                                               input logic [10:0] offset);
    return pc + 16'd1 + {{5{offset[10]}}, offset};
  endfunction

endpackage

// File: rtl/pc_fetch_fifo.sv
// fetch_fifo: two-entry instruction buffer between the fetch handshake and IF/ID.
// A push and a pop on the same edge keep the count; flush empties it at once.
module fetch_fifo
  import pc_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [15:0] pushAddr_i,
  input  logic [15:0] pushInstr_i,
  input  logic        pushPred_i,
  output logic [15:0] headAddr_o,
  output logic [15:0] headInstr_o,
  output logic        headPred_o,
  output logic [1:0]  count_o
);

  fetch_entry_t entry_q [FIFO_DEPTH];
  logic         rdPtr_q, rdPtr_d;
  logic         wrPtr_q, wrPtr_d;
  logic [1:0]   count_q, count_d;
  logic         doPush;
  logic         doPop;
  fetch_entry_t head;

  // With a depth of two, one-bit pointers wrap simply by toggling.
  always_comb begin
    doPop   = pop_i && (count_q != 2'd0);
    doPush  = push_i && ((count_q != FIFO_FULL) || doPop);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = 1'b0;
      wrPtr_d = 1'b0;
      count_d = 2'd0;
    end else begin
      if (doPop) begin
        rdPtr_d = ~rdPtr_q;
      end
      if (doPush) begin
        wrPtr_d = ~wrPtr_q;
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && doPush) begin
      entry_q[wrPtr_q] <= '{addr: pushAddr_i, instr: pushInstr_i, pred: pushPred_i};
    end
  end

  always_comb begin
    head = '0;
    if (count_q != 2'd0) begin
      head = entry_q[rdPtr_q];
    end
    headAddr_o  = head.addr;
    headInstr_o = head.instr;
    headPred_o  = head.pred;
    count_o     = count_q;
  end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter, memory request handshake and redirect handling.
// Optional static predecode of unconditional B is built when PC_FETCH_PREDECODE_EN is defined.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        pfi_clk,
  input  logic        pfi_rst,
  input  logic        pfi_keep,
  input  logic        pfi_redirect,
  input  logic [15:0] pfi_target,
  output logic        pfo_mem_req,
  output logic [15:0] pfo_mem_addr,
  input  logic        pfi_mem_ack,
  input  logic [15:0] pfi_mem_data,
  output logic        pfo_valid,
  output logic [15:0] pfo_addr,
  output logic [15:0] pfo_instr,
  output logic        pfo_pred
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         pending_q, pending_d;
  logic [15:0]  reqAddr_q, reqAddr_d;

  logic [1:0]   fifoCount;
  logic [15:0]  headAddr;
  logic [15:0]  headInstr;
  logic         headPred;

  logic         consume;
  logic         issueNew;
  logic         reqRaw;
  logic [15:0]  reqAddr;
  logic         ackHit;
  logic         push;
  logic         predHit;
  logic [15:0]  nextPc;

  fetch_fifo u_fifo (
    .clk_i       (pfi_clk),
    .rst_i       (pfi_rst),
    .push_i      (push),
    .pop_i       (consume),
    .flush_i     (pfi_redirect),
    .pushAddr_i  (pc_q),
    .pushInstr_i (pfi_mem_data),
    .pushPred_i  (predHit),
    .headAddr_o  (headAddr),
    .headInstr_o (headInstr),
    .headPred_o  (headPred),
    .count_o     (fifoCount)
  );

  always_ff @(posedge pfi_clk) begin
    if (pfi_rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      reqAddr_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      reqAddr_q <= reqAddr_d;
    end
  end

  // A request that went unacknowledged stays frozen at its address, even
  // across a redirect; only acks that meet an asserted request count.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push      = 1'b0;
    predHit   = 1'b0;
    nextPc    = pc_q + 16'd1;

    consume   = (fifoCount != 2'd0) && !pfi_redirect && !pfi_keep;
    issueNew  = (state_q == ST_FETCH) && ((fifoCount != FIFO_FULL) || consume);
    reqRaw    = pending_q || issueNew;
    reqAddr   = pending_q ? reqAddr_q : pc_q;
    ackHit    = pfi_mem_ack && reqRaw && !pfi_rst;
    pending_d = reqRaw && !ackHit;
    reqAddr_d = reqAddr;

`ifdef PC_FETCH_PREDECODE_EN
    if (pfi_mem_data[15:11] == OP_B) begin
      predHit = 1'b1;
      nextPc  = branchTarget(pc_q, pfi_mem_data[10:0]);
    end
`endif

    case (state_q)
      ST_FETCH: begin
        if (pfi_redirect) begin
          pc_d = pfi_target;
          if (reqRaw && !ackHit) begin
            state_d = ST_DROP;
          end
        end else if (ackHit) begin
          push = 1'b1;
          pc_d = nextPc;
        end
      end
      ST_DROP: begin
        if (pfi_redirect) begin
          pc_d = pfi_target;
        end
        if (ackHit) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pfo_mem_req  = reqRaw && !pfi_rst;
    pfo_mem_addr = pfi_rst ? 16'h0000 : reqAddr;
    pfo_valid    = (fifoCount != 2'd0) && !pfi_redirect && !pfi_rst;
    pfo_addr     = pfi_rst ? 16'h0000 : headAddr;
    pfo_instr    = pfi_rst ? 16'h0000 : headInstr;
    pfo_pred     = pfi_rst ? 1'b0 : headPred;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the 16-bit pipeline, directly upstream of the IF/ID register. Owns the program counter and issues word reads on the instruction-memory handshake. Buffers up to two returned instructions, presents them with their PC to IF/ID, and honours downstream hold and branch/jump redirects from later stages.

## Interface
- RESET_PC, 16'h0000, PC value loaded by reset.
- pfi_clk  in  1  clock; all state updates on its rising edge.
- pfi_rst  in  1  synchronous, active-high reset.
- pfi_keep  in  1  downstream hold; the head entry is not consumed.
- pfi_redirect  in  1  single-cycle redirect from EX/MEM.
- pfi_target  in  16  redirect PC, valid with pfi_redirect.
- pfo_mem_req  out  1  fetch request.
- pfo_mem_addr  out  16  fetch word address.
- pfi_mem_ack  in  1  one-cycle acknowledge; pfi_mem_data valid this cycle.
- pfi_mem_data  in  16  fetched instruction.
- pfo_valid  out  1  head entry presented; drives the IF/ID enable.
- pfo_addr  out  16  PC of the head entry.
- pfo_instr  out  16  instruction of the head entry.
- pfo_pred  out  1  head entry was predecoded as a taken B.

## Operation
- State: pc (next fetch address), 2-entry FIFO {addr, instr, pred}, count 0..2, FSM {FETCH, DROP}.
- Issue rule in FETCH: pfo_mem_req=1 when (count + outstanding) < 2, or when count==2 and the head is consumed this cycle. pfo_mem_addr=pc.
- Once asserted, req and addr hold stable until ack, regardless of keep or redirect.
- On ack in FETCH: push {pc, data, pred}, pc <= next_pc. next_pc = pc+1, with 16-bit wrap (16'hFFFF -> 16'h0000).
- Consume: head popped on an edge where pfo_valid=1 and pfi_keep=0. A push and a pop on the same edge leave count unchanged.
- pfo_valid = (count!=0) && !pfi_redirect. pfo_addr, pfo_instr and pfo_pred come from the head, and are 0 when count==0.
- Redirect: FIFO flushed (count <= 0) and pc <= pfi_target.
  - Request outstanding and unacked, with no ack this cycle: FSM -> DROP. The request stays at its old address until ack, then the data is discarded and the FSM returns to FETCH.
  - Ack in the same cycle as redirect: the data is discarded and no DROP is needed.
- Redirect beats keep. Redirect in DROP updates pc only.
- Reset: pc=RESET_PC, count=0, FSM=FETCH, all outputs 0.

## Timing
- Zero-wait memory (ack in the same cycle as req): 1 instruction/cycle sustained, first pfo_valid 1 cycle after reset deasserts.
- Redirect at edge N: first target request in cycle N+1 (FETCH), or in the cycle after the discarded ack (DROP).
- keep held with count==2: req low, FIFO frozen.
- Reset asserted mid-request: request dropped, any ack in the following cycles ignored until the first new req.

## Configuration
- PC_FETCH_PREDECODE_EN defined: on ack, if data[15:11]==5'b00010 (unconditional B), next_pc = pc+1+sext(data[10:0]) and the entry's pred=1. EX skips its redirect for entries with pred=1.
- Undefined: next_pc is always pc+1 and pfo_pred is tied to 0.

## Structure
- Shared package holds the RESET_PC default, opcode constant OP_B=5'b00010, the FSM state encoding and the FIFO depth constant (2).
- Sub-module fetch_fifo (2-entry, push/pop/flush, count output). The PC/FSM/predecode logic stays in pc_fetch.

## Test plan
- Reset, zero-wait memory returning data = addr ^ 16'hA5A5, keep=0: pfo_addr runs 0,1,2,3 on consecutive cycles with pfo_valid=1.
- keep=1 for 4 cycles from PC 2: count reaches 2, req drops, pfo_addr stays 2. Release: 2,3,4 continue with no gap or duplicate.
- Memory with 3-cycle ack latency, redirect to 16'h0040 one cycle after req for 16'h0005: 16'h0005 data discarded, next req addr 16'h0040, pfo_valid=0 throughout.
- Redirect in the same cycle as ack: ack data not presented, next req at target, pfo_valid=0 that cycle.
- RESET_PC=16'hFFFF: fetches FFFF then 0000.
- Predecode enabled, instr 16'h17FE at PC 16'h0010: next fetch at 16'h000F and pfo_pred=1. Predecode disabled: next fetch at 16'h0011 and pfo_pred=0.
